// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: dispatch payload, free-register return
// and the per-entry record held in the ROB.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int PREG_W    = 6;
  localparam int PC_W      = 32;

  typedef struct packed {
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [PC_W-1:0]   pc;
  } dispatchStruct;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] reg_addr;
  } freeRegStruct;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [PC_W-1:0]   pc;
  } robEntryStruct;

endpackage

// File: rtl/rob_retire_sel.sv
// Picks up to two in-order retirements from the head of the ROB and forms the
// matching free-register requests (physical register 0 is never freed).
module rob_retire_sel
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]  i_head,
  input  logic [TAG_W-1:0]  i_head1,
  input  logic [DEPTH-1:0]  i_valid,
  input  logic [DEPTH-1:0]  i_done,
  input  logic [PREG_W-1:0] i_rd_old [DEPTH],
  output logic              o_retire0,
  output logic              o_retire1,
  output logic              o_free_valid_a,
  output logic              o_free_valid_b,
  output logic [PREG_W-1:0] o_free_addr_a,
  output logic [PREG_W-1:0] o_free_addr_b
);

  logic [PREG_W-1:0] w_old0;
  logic [PREG_W-1:0] w_old1;

  assign w_old0 = i_rd_old[i_head];
  assign w_old1 = i_rd_old[i_head1];

  assign o_retire0 = i_valid[i_head] && i_done[i_head];
  assign o_retire1 = o_retire0 && i_valid[i_head1] && i_done[i_head1];

  // Ports stay positional: a zero rd_old in slot 0 does not shift slot 1 down.
  assign o_free_valid_a = o_retire0 && (w_old0 != '0);
  assign o_free_valid_b = o_retire1 && (w_old1 != '0);
  assign o_free_addr_a  = o_retire0 ? w_old0 : '0;
  assign o_free_addr_b  = o_retire1 ? w_old1 : '0;

endmodule

// File: rtl/rob.sv
// Dual-issue reorder buffer: allocates two tags per cycle, marks entries done on
// completion broadcasts and retires up to two done entries per cycle in order.
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  dispatchStruct    dispatch_a,
  input  dispatchStruct    dispatch_b,
  input  logic             alloc_valid_a,
  input  logic             alloc_valid_b,
  output logic             rob_stall,
  output logic [TAG_W-1:0] rob_tag_a,
  output logic [TAG_W-1:0] rob_tag_b,
  input  logic             cmpl_valid_a,
  input  logic             cmpl_valid_b,
  input  logic [TAG_W-1:0] cmpl_tag_a,
  input  logic [TAG_W-1:0] cmpl_tag_b,
  output freeRegStruct     freeReg_a,
  output freeRegStruct     freeReg_b,
  output logic [1:0]       retire_cnt,
  output logic             rob_empty
);

  robEntryStruct r_entries [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_done;
  logic [PREG_W-1:0] w_rd_old [DEPTH];
  logic [TAG_W-1:0]  w_head1;
  logic              w_alloc_a;
  logic              w_alloc_b;
  logic [1:0]        w_n_alloc;
  logic [1:0]        w_n_retire;
  logic              w_retire0;
  logic              w_retire1;
  logic              w_free_valid_a;
  logic              w_free_valid_b;
  logic [PREG_W-1:0] w_free_addr_a;
  logic [PREG_W-1:0] w_free_addr_b;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i]  = r_entries[i].valid;
      w_done[i]   = r_entries[i].done;
      w_rd_old[i] = r_entries[i].rd_old;
    end
  end

  // Stall looks only at the registered count, not at this cycle's retirements.
  assign rob_stall = r_count > (TAG_W+1)'(DEPTH - 2);
  assign rob_empty = (r_count == '0);
  assign rob_tag_a = r_tail;
  assign rob_tag_b = r_tail + TAG_W'(alloc_valid_a);
  assign w_head1   = r_head + TAG_W'(1);

  assign w_alloc_a  = alloc_valid_a && !rob_stall;
  assign w_alloc_b  = alloc_valid_b && !rob_stall;
  assign w_n_alloc  = {1'b0, w_alloc_a} + {1'b0, w_alloc_b};
  assign w_n_retire = {1'b0, w_retire0} + {1'b0, w_retire1};

  rob_retire_sel #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_retire_sel (
    .i_head         (r_head),
    .i_head1        (w_head1),
    .i_valid        (w_valid),
    .i_done         (w_done),
    .i_rd_old       (w_rd_old),
    .o_retire0      (w_retire0),
    .o_retire1      (w_retire1),
    .o_free_valid_a (w_free_valid_a),
    .o_free_valid_b (w_free_valid_b),
    .o_free_addr_a  (w_free_addr_a),
    .o_free_addr_b  (w_free_addr_b)
  );

  // Allocation, completion and retirement always touch disjoint entries, so their order here is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_alloc_a) begin
        r_entries[rob_tag_a] <= '{valid: 1'b1, done: 1'b0, rd: dispatch_a.rd,
                                  rd_old: dispatch_a.rd_old, pc: dispatch_a.pc};
      end
      if (w_alloc_b) begin
        r_entries[rob_tag_b] <= '{valid: 1'b1, done: 1'b0, rd: dispatch_b.rd,
                                  rd_old: dispatch_b.rd_old, pc: dispatch_b.pc};
      end
      if (cmpl_valid_a && r_entries[cmpl_tag_a].valid) begin
        r_entries[cmpl_tag_a].done <= 1'b1;
      end
      if (cmpl_valid_b && r_entries[cmpl_tag_b].valid) begin
        r_entries[cmpl_tag_b].done <= 1'b1;
      end
      if (w_retire0) begin
        r_entries[r_head].valid <= 1'b0;
        r_entries[r_head].done  <= 1'b0;
      end
      if (w_retire1) begin
        r_entries[w_head1].valid <= 1'b0;
        r_entries[w_head1].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      freeReg_a  <= '0;
      freeReg_b  <= '0;
      retire_cnt <= '0;
    end else begin
      r_head     <= r_head + TAG_W'(w_n_retire);
      r_tail     <= r_tail + TAG_W'(w_n_alloc);
      r_count    <= r_count + (TAG_W+1)'(w_n_alloc) - (TAG_W+1)'(w_n_retire);
      freeReg_a  <= '{valid: w_free_valid_a, reg_addr: w_free_addr_a};
      freeReg_b  <= '{valid: w_free_valid_b, reg_addr: w_free_addr_b};
      retire_cnt <= w_n_retire;
    end
  end

  a_cmpl_a_live: assert property (@(posedge clk) disable iff (!reset_n)
    cmpl_valid_a |-> r_entries[cmpl_tag_a].valid);
  a_cmpl_b_live: assert property (@(posedge clk) disable iff (!reset_n)
    cmpl_valid_b |-> r_entries[cmpl_tag_b].valid);

endmodule
